// File: rtl/sub_bus_ram_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | sub_bus_ram_arbiter_if : requester ports A/B plus RAM bus of the arbiter  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sub_bus_ram_arbiter_if;
  logic        i_a_req;
  logic        i_a_lock;
  logic        i_a_we;
  logic [15:0] i_a_addr;
  logic [15:0] i_a_wdata;
  logic        o_a_gnt;
  logic        o_a_rvalid;
  logic [15:0] o_a_rdata;

  logic        i_b_req;
  logic        i_b_lock;
  logic        i_b_we;
  logic [15:0] i_b_addr;
  logic [15:0] i_b_wdata;
  logic        o_b_gnt;
  logic        o_b_rvalid;
  logic [15:0] o_b_rdata;

  logic        o_bus_we;
  logic [15:0] o_bus_addr;
  logic [15:0] o_bus_data_write;
  logic [15:0] i_bus_data_read;
  logic        o_err;

  modport slave (
    input  i_a_req, i_a_lock, i_a_we, i_a_addr, i_a_wdata,
    output o_a_gnt, o_a_rvalid, o_a_rdata,
    input  i_b_req, i_b_lock, i_b_we, i_b_addr, i_b_wdata,
    output o_b_gnt, o_b_rvalid, o_b_rdata,
    output o_bus_we, o_bus_addr, o_bus_data_write,
    input  i_bus_data_read,
    output o_err
  );

  modport master (
    output i_a_req, i_a_lock, i_a_we, i_a_addr, i_a_wdata,
    input  o_a_gnt, o_a_rvalid, o_a_rdata,
    output i_b_req, i_b_lock, i_b_we, i_b_addr, i_b_wdata,
    input  o_b_gnt, o_b_rvalid, o_b_rdata,
    input  o_bus_we, o_bus_addr, o_bus_data_write,
    output i_bus_data_read,
    input  o_err
  );
endinterface

`default_nettype wire

// File: rtl/sub_bus_ram_arbiter.sv
// +----------------------------------------------------------------------------+
// | sub_bus_ram_arbiter : two-port arbiter in front of a 1-cycle sync RAM.    |
// | Define SUB_BUS_ARB_ROUND_ROBIN_EN for round-robin ties (else A wins ties). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sub_bus_ram_arbiter #(
  parameter int ADDRESS_SIZE = 48896,
  parameter int LOCK_MAX     = 16
) (
  input  wire logic             bus_clock,
  input  wire logic             reset,
  sub_bus_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  localparam logic [16:0] C_ADDR_LIM = 17'(ADDRESS_SIZE);
  localparam logic [7:0]  C_LOCK_MAX = 8'(LOCK_MAX);

  owner_e      owner_q, owner_d;
  logic        owner_lock_q, owner_lock_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        rvalid_a_q, rvalid_b_q;
  logic        oor_q;
  logic [15:0] addr_q;
`ifdef SUB_BUS_ARB_ROUND_ROBIN_EN
  logic        last_b_q;
`endif

  logic        w_gnt_a, w_gnt_b, w_gnt;
  logic        w_own_req, w_lock_live, w_lock_spent, w_spent_same;
  logic        w_win_we, w_win_lock, w_in_range;
  logic [15:0] w_win_addr, w_win_wdata, w_bus_addr;

  assign w_own_req    = (owner_q == OWN_A) ? bus.i_a_req :
                        (owner_q == OWN_B) ? bus.i_b_req : 1'b0;
  assign w_lock_live  = owner_lock_q && (lock_cnt_q <  C_LOCK_MAX);
  assign w_lock_spent = owner_lock_q && (lock_cnt_q >= C_LOCK_MAX);

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      w_gnt_a = 1'b0;
    end else if (w_lock_live && w_own_req) begin
      w_gnt_a = (owner_q == OWN_A);
      w_gnt_b = (owner_q == OWN_B);
    end else if (w_lock_spent && (owner_q == OWN_A) && bus.i_b_req) begin
      // An exhausted lock hands one arbitration to the waiting port.
      w_gnt_b = 1'b1;
    end else if (w_lock_spent && (owner_q == OWN_B) && bus.i_a_req) begin
      w_gnt_a = 1'b1;
    end else if (bus.i_a_req && !bus.i_b_req) begin
      w_gnt_a = 1'b1;
    end else if (bus.i_b_req && !bus.i_a_req) begin
      w_gnt_b = 1'b1;
    end else if (bus.i_a_req && bus.i_b_req) begin
`ifdef SUB_BUS_ARB_ROUND_ROBIN_EN
      w_gnt_a = last_b_q;
      w_gnt_b = !last_b_q;
`else
      w_gnt_a = 1'b1;
`endif
    end
  end

  assign w_gnt       = w_gnt_a | w_gnt_b;
  assign w_win_we    = w_gnt_b ? bus.i_b_we    : bus.i_a_we;
  assign w_win_lock  = w_gnt_b ? bus.i_b_lock  : bus.i_a_lock;
  assign w_win_addr  = w_gnt_b ? bus.i_b_addr  : bus.i_a_addr;
  assign w_win_wdata = w_gnt_b ? bus.i_b_wdata : bus.i_a_wdata;
  assign w_in_range  = ({1'b0, w_win_addr} < C_ADDR_LIM);
  assign w_bus_addr  = w_gnt ? w_win_addr : addr_q;

  assign w_spent_same = w_lock_spent &&
                        ((w_gnt_a && (owner_q == OWN_A)) || (w_gnt_b && (owner_q == OWN_B)));

  always_comb begin
    owner_d      = w_gnt_a ? OWN_A : (w_gnt_b ? OWN_B : IDLE);
    owner_lock_d = w_gnt && w_win_lock && !w_spent_same;
    lock_cnt_d   = 8'd0;
    if (owner_lock_d) begin
      lock_cnt_d = (owner_d == owner_q) ? (lock_cnt_q + 8'd1) : 8'd1;
    end
  end

  always_ff @(posedge bus_clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= IDLE;
      owner_lock_q <= 1'b0;
      lock_cnt_q   <= 8'd0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      oor_q        <= 1'b0;
      addr_q       <= 16'h0000;
`ifdef SUB_BUS_ARB_ROUND_ROBIN_EN
      last_b_q     <= 1'b1;
`endif
    end else begin
      owner_q      <= owner_d;
      owner_lock_q <= owner_lock_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid_a_q   <= w_gnt_a;
      rvalid_b_q   <= w_gnt_b;
      oor_q        <= w_gnt && !w_in_range;
      addr_q       <= w_bus_addr;
`ifdef SUB_BUS_ARB_ROUND_ROBIN_EN
      if (w_gnt) begin
        last_b_q <= w_gnt_b;
      end
`endif
    end
  end

  assign bus.o_a_gnt          = w_gnt_a;
  assign bus.o_b_gnt          = w_gnt_b;
  assign bus.o_bus_we         = w_gnt && w_win_we && w_in_range;
  assign bus.o_bus_addr       = w_bus_addr;
  assign bus.o_bus_data_write = w_gnt ? w_win_wdata : 16'h0000;

  // Read data arrives from the RAM in the rvalid cycle; out-of-range returns zero.
  assign bus.o_a_rvalid = rvalid_a_q;
  assign bus.o_b_rvalid = rvalid_b_q;
  assign bus.o_a_rdata  = (rvalid_a_q && !oor_q) ? bus.i_bus_data_read : 16'h0000;
  assign bus.o_b_rdata  = (rvalid_b_q && !oor_q) ? bus.i_bus_data_read : 16'h0000;
  assign bus.o_err      = oor_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_bus_ram_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_sub_bus_ram_arbiter : randomized scoreboard bench for the RAM arbiter  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sub_bus_ram_arbiter;
  localparam int ADDRESS_SIZE = 48896;
  localparam int LOCK_MAX     = 16;

  typedef struct packed {
    logic        v;
    logic        lock;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    int          due;
    bit          port_b;
    logic [15:0] rdata;
    bit          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub_bus_ram_arbiter_if bus_if();

  sub_bus_ram_arbiter #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .LOCK_MAX     (LOCK_MAX)
  ) dut (
    .bus_clock (clk),
    .reset     (rst_n),
    .bus       (bus_if)
  );

  // RAM: one-cycle synchronous read, old data on read-during-write
  logic [15:0] ram [0:65535];
  logic [15:0] rd_q = 16'h0000;
  always @(posedge clk) begin
    rd_q <= ram[bus_if.o_bus_addr];
    if (bus_if.o_bus_we) ram[bus_if.o_bus_addr] <= bus_if.o_bus_data_write;
  end
  assign bus_if.i_bus_data_read = rd_q;

  // Reference model state
  logic [15:0] mem_m [0:65535];
  int   m_owner = 0;
  bit   m_locked = 0;
  int   m_run = 0;
  int   m_last = 2;
  req_t pa, pb;
  exp_t q[$];
  int   cyc = 0;
  int   dut_w = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(bit lock, bit we, logic [15:0] addr, logic [15:0] wdata);
    req_t r;
    r.v = 1'b1; r.lock = lock; r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    int   sel;
    logic [15:0] a;
    sel = $urandom_range(0, 9);
    if (sel <= 6)      a = 16'($urandom_range(0, 31));
    else if (sel == 7) a = 16'hBEFF;
    else if (sel == 8) a = 16'hBF00;
    else               a = 16'($urandom_range(16'hBF00, 16'hFFFF));
    return mk($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)), a, 16'($urandom));
  endfunction

  // Winner from the arbitration rules: live lock, spent lock, single request, tie
  function automatic int m_decide();
    bit ra, rb, own_req, oth_req;
    int oth;
    ra      = pa.v;
    rb      = pb.v;
    own_req = (m_owner == 1) ? ra : (m_owner == 2) ? rb : 1'b0;
    oth     = (m_owner == 1) ? 2 : 1;
    oth_req = (m_owner == 1) ? rb : ra;
    if (m_locked && own_req && m_run < LOCK_MAX) return m_owner;
    if (m_locked && m_run >= LOCK_MAX && oth_req) return oth;
    if (ra && rb) begin
`ifdef SUB_BUS_ARB_ROUND_ROBIN_EN
      return (m_last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  task automatic m_update(int w, bit lk);
    bit spent;
    spent = m_locked && (m_run >= LOCK_MAX) && (w == m_owner);
    if (w == 0) begin
      m_locked = 0; m_run = 0;
    end else begin
      if (lk && !spent) begin
        m_run    = (w == m_owner && m_locked) ? m_run + 1 : 1;
        m_locked = 1;
      end else begin
        m_run = 0; m_locked = 0;
      end
      m_last = w;
    end
    m_owner = w;
  endtask

  task automatic drive();
    bus_if.i_a_req = pa.v;  bus_if.i_a_lock = pa.lock; bus_if.i_a_we = pa.we;
    bus_if.i_a_addr = pa.addr; bus_if.i_a_wdata = pa.wdata;
    bus_if.i_b_req = pb.v;  bus_if.i_b_lock = pb.lock; bus_if.i_b_we = pb.we;
    bus_if.i_b_addr = pb.addr; bus_if.i_b_wdata = pb.wdata;
  endtask

  task automatic eval_cycle();
    int   w;
    bit   in_r;
    req_t r;
    exp_t e;
    w = m_decide();
    dut_w = bus_if.o_a_gnt ? 1 : (bus_if.o_b_gnt ? 2 : 0);
    chk("gnt_a", bus_if.o_a_gnt, w == 1);
    chk("gnt_b", bus_if.o_b_gnt, w == 2);
    if (w != 0) begin
      r    = (w == 1) ? pa : pb;
      in_r = (r.addr < ADDRESS_SIZE);
      chk("bus_addr", bus_if.o_bus_addr, r.addr);
      chk("bus_we", bus_if.o_bus_we, r.we && in_r);
      if (r.we) chk("bus_wdata", bus_if.o_bus_data_write, r.wdata);
      e.due    = cyc + 1;
      e.port_b = (w == 2);
      e.rdata  = in_r ? mem_m[r.addr] : 16'h0000;
      e.err    = !in_r;
      q.push_back(e);
      if (r.we && in_r) mem_m[r.addr] = r.wdata;
      m_update(w, r.lock);
      if (w == 1) pa.v = 1'b0; else pb.v = 1'b0;
    end else begin
      chk("bus_we_idle", bus_if.o_bus_we, 0);
      chk("bus_wdata_idle", bus_if.o_bus_data_write, 0);
      m_update(0, 1'b0);
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a response is due
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rvalid_a", bus_if.o_a_rvalid, !e.port_b);
      chk("rvalid_b", bus_if.o_b_rvalid, e.port_b);
      chk("rdata", e.port_b ? bus_if.o_b_rdata : bus_if.o_a_rdata, e.rdata);
      chk("err", bus_if.o_err, e.err);
    end else if (bus_if.o_a_rvalid || bus_if.o_b_rvalid || bus_if.o_err) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rvalid: got a=%0b b=%0b err=%0b expected none (cycle %0d)",
               bus_if.o_a_rvalid, bus_if.o_b_rvalid, bus_if.o_err, cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ag, bg, first_b, after_b;
    for (int i = 0; i < 65536; i++) begin
      ram[i]   = 16'h17FF ^ 16'(i * 7);
      mem_m[i] = 16'h17FF ^ 16'(i * 7);
    end
    pa = mk(1'b0, 1'b0, 16'h0000, 16'h0000);
    pb = '0;
    drive();
    @(negedge clk);
    chk("rst_gnt_a", bus_if.o_a_gnt, 0);
    chk("rst_rvalid_a", bus_if.o_a_rvalid, 0);
    chk("rst_err", bus_if.o_err, 0);
    chk("rst_bus_addr", bus_if.o_bus_addr, 0);
    chk("rst_bus_we", bus_if.o_bus_we, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step();
    pb = '0;
    step();

    // write then read same address
    pa = mk(1'b0, 1'b1, 16'h0020, 16'hA5A5);
    step();
    pa = mk(1'b0, 1'b0, 16'h0020, 16'h0000);
    step();
    step();

    // tie behaviour with both ports always requesting
    pb = mk(1'b0, 1'b0, 16'h0040, 16'h0000);
    step();
    bg = 0;
    for (int i = 0; i < 8; i++) begin
      if (!pa.v) pa = mk(1'b0, 1'b1, 16'h0010, 16'h1234);
      if (!pb.v) pb = mk(1'b0, 1'b0, 16'h0010, 16'h0000);
      step();
      if (dut_w == 2) bg++;
    end
`ifdef SUB_BUS_ARB_ROUND_ROBIN_EN
    chk("tie_b_grants", bg, 4);
`else
    chk("tie_b_grants", bg, 0);
`endif
    pa = '0; pb = '0;
    step();

    // A locked burst of 20 against a continuously requesting B
    ag = 0; first_b = -1; after_b = -1;
    for (int i = 0; i < 60 && ag < 20; i++) begin
      if (!pa.v) pa = mk(1'b1, 1'b0, 16'(16'h0100 + ag), 16'h0000);
      if (!pb.v) pb = mk(1'b0, 1'b0, 16'h0030, 16'h0000);
      step();
      if (first_b >= 0 && after_b < 0) after_b = dut_w;
      if (dut_w == 1) ag++;
      if (dut_w == 2 && first_b < 0) first_b = ag;
    end
    chk("lock_a_before_b", first_b, LOCK_MAX);
    chk("lock_resume_a", after_b, 1);
    chk("lock_a_total", ag, 20);
    pa = '0; pb = '0;
    step();

    // out of range write, then in-range boundary read
    pb = mk(1'b0, 1'b1, 16'hBF00, 16'hBEEF);
    step();
    pb = mk(1'b0, 1'b0, 16'hBEFF, 16'h0000);
    step();
    step();

    // reset between a read grant and its data return
    pa = mk(1'b0, 1'b0, 16'h0005, 16'h0000);
    drive();
    @(negedge clk);
    eval_cycle();
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_gnt_a", bus_if.o_a_gnt, 0);
    chk("midrst_rvalid_a", bus_if.o_a_rvalid, 0);
    chk("midrst_err", bus_if.o_err, 0);
    chk("midrst_bus_we", bus_if.o_bus_we, 0);
    chk("midrst_bus_addr", bus_if.o_bus_addr, 0);
    @(posedge clk);
    #1 chk("midrst_rvalid_hold", bus_if.o_a_rvalid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_owner = 0; m_locked = 0; m_run = 0; m_last = 2;
    pa = mk(1'b0, 1'b0, 16'h0006, 16'h0000);
    pb = mk(1'b0, 1'b0, 16'h0007, 16'h0000);
    step();
    chk("post_reset_tie", dut_w, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!pa.v && $urandom_range(0, 99) < 60) pa = rand_req();
      if (!pb.v && $urandom_range(0, 99) < 60) pb = rand_req();
      else if (pb.v && $urandom_range(0, 99) < 5) pb.v = 1'b0;
      step();
    end

    pa = '0; pb = '0;
    for (int i = 0; i < 3; i++) step();
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
